// File: rtl/subtract_16.sv
// subtract_16: registered 16-bit two's-complement subtractor (result = a - b).
// The datapath forms a + ~b + 1 using four 4-bit carry-lookahead groups and a
// second lookahead level across the groups. Status flags come from the same sum.
// Every flag is registered in the same cycle as result.
module subtract_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        in_valid,
   output logic [15:0] result,
   output logic        out_valid,
   output logic        borrow,
   output logic        overflow,
   output logic        zero,
   output logic        negative
);

   // Group generate: the 4-bit group produces a carry on its own.
   function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
      grp_gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   // Carries into bits 0..3 of one group, all computed from the group carry-in.
   function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p,
                                             input logic cin);
      logic [3:0] c;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      cla4_carry = c;
   endfunction

   logic [15:0] b_inv_s;
   logic [15:0] gen_s;
   logic [15:0] prop_s;
   logic [3:0]  grp_g_s;
   logic [3:0]  grp_p_s;
   logic [4:0]  grp_c_s;     // carry into each group; [4] is the adder carry-out
   logic [15:0] carry_s;     // carry into each bit
   logic [15:0] sum_s;
   logic        borrow_s;
   logic        overflow_s;
   logic        zero_s;

   // Per-bit and per-group generate/propagate terms for a + ~b.
   always_comb begin
      b_inv_s = ~b;
      gen_s   = a & b_inv_s;
      prop_s  = a ^ b_inv_s;
      grp_g_s = 4'd0;
      grp_p_s = 4'd0;
      for (int k = 0; k < 4; k++) begin
         grp_g_s[k] = grp_gen(gen_s[4*k +: 4], prop_s[4*k +: 4]);
         grp_p_s[k] = &prop_s[4*k +: 4];
      end
   end

   // Second-level lookahead: group carries from the fixed carry-in of 1.
   always_comb begin
      grp_c_s    = 5'd0;
      grp_c_s[0] = 1'b1;
      grp_c_s[1] = grp_g_s[0] | (grp_p_s[0] & grp_c_s[0]);
      grp_c_s[2] = grp_g_s[1] | (grp_p_s[1] & grp_g_s[0])
                 | (grp_p_s[1] & grp_p_s[0] & grp_c_s[0]);
      grp_c_s[3] = grp_g_s[2] | (grp_p_s[2] & grp_g_s[1])
                 | (grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
                 | (grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & grp_c_s[0]);
      grp_c_s[4] = grp_g_s[3] | (grp_p_s[3] & grp_g_s[2])
                 | (grp_p_s[3] & grp_p_s[2] & grp_g_s[1])
                 | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
                 | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & grp_c_s[0]);
   end

   // In-group carries, sum bits and the status flags derived from that sum.
   always_comb begin
      carry_s = 16'd0;
      for (int k = 0; k < 4; k++) begin
         carry_s[4*k +: 4] = cla4_carry(gen_s[4*k +: 4], prop_s[4*k +: 4], grp_c_s[k]);
      end
      sum_s      = prop_s ^ carry_s;
      borrow_s   = ~grp_c_s[4];
      overflow_s = (a[15] ^ b[15]) & (sum_s[15] ^ a[15]);
      zero_s     = (sum_s == 16'h0000);
   end

   // Output registers: reset wins, a valid pair loads, otherwise hold and drop valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result    <= 16'h0000;
         out_valid <= 1'b0;
         borrow    <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b1;
         negative  <= 1'b0;
      end else if (in_valid) begin
         result    <= sum_s;
         out_valid <= 1'b1;
         borrow    <= borrow_s;
         overflow  <= overflow_s;
         zero      <= zero_s;
         negative  <= sum_s[15];
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_subtract_16.sv
// Directed bench for subtract_16 with a short randomized tail checked against
// a 17-bit arithmetic reference. Inputs change on the falling edge; outputs
// are sampled on the following falling edge.
module tb_subtract_16;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        in_valid;
   logic [15:0] result;
   logic        out_valid;
   logic        borrow;
   logic        overflow;
   logic        zero;
   logic        negative;

   int n_cmp;
   int n_err;

   subtract_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .result    (result),
      .out_valid (out_valid),
      .borrow    (borrow),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string field,
                      input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s.%s observed=0x%04h expected=0x%04h", tag, field, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] e_res, input logic e_ov,
                          input logic e_bor, input logic e_ovf, input logic e_z,
                          input logic e_neg);
      chk(tag, "result",    result,             e_res);
      chk(tag, "out_valid", {15'd0, out_valid}, {15'd0, e_ov});
      chk(tag, "borrow",    {15'd0, borrow},    {15'd0, e_bor});
      chk(tag, "overflow",  {15'd0, overflow},  {15'd0, e_ovf});
      chk(tag, "zero",      {15'd0, zero},      {15'd0, e_z});
      chk(tag, "negative",  {15'd0, negative},  {15'd0, e_neg});
   endtask

   task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic v);
      a        = av;
      b        = bv;
      in_valid = v;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [16:0] diff;
      logic [15:0] m_res;
      logic        m_bor;
      logic        m_ovf;
      logic        m_z;
      logic        m_neg;
      logic        m_ov;
      int          accepted;
      int          pulses;

      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      drive(16'h0000, 16'h0000, 1'b0);

      // Reset for two cycles
      @(negedge clk);
      next_cycle();
      next_cycle();
      chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;

      // 4976 - 6789 = -1813
      drive(16'h1370, 16'h1A85, 1'b1);
      next_cycle();
      chk_all("basic", 16'hF8EB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(16'hAAAA, 16'h5555, 1'b0);
      next_cycle();
      chk_all("basic_hold", 16'hF8EB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

      // Overflow boundaries back-to-back
      drive(16'h8000, 16'h0001, 1'b1);
      next_cycle();
      chk_all("ovf_neg", 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(16'h7FFF, 16'hFFFF, 1'b1);
      next_cycle();
      chk_all("ovf_pos", 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

      // Zero and wrap cases, back-to-back
      drive(16'h1234, 16'h1234, 1'b1);
      next_cycle();
      chk_all("zero", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(16'h0000, 16'hFFFF, 1'b1);
      next_cycle();
      chk_all("wrap_up", 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(16'hFFFF, 16'h0000, 1'b1);
      next_cycle();
      chk_all("neg_one", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(16'h0000, 16'h0000, 1'b0);
      next_cycle();
      chk_all("idle", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Operand changes while idle have no effect
      drive(16'h0001, 16'h0002, 1'b0);
      next_cycle();
      chk_all("idle_change", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset priority over a valid pair, with a result pending before it
      drive(16'h0010, 16'h0001, 1'b1);
      next_cycle();
      chk_all("pre_rst", 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      drive(16'h0005, 16'h0003, 1'b1);
      next_cycle();
      chk_all("rst_prio", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      drive(16'h0005, 16'h0003, 1'b0);
      next_cycle();
      chk_all("rst_no_pulse", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // First valid after release is accepted
      drive(16'h0005, 16'h0003, 1'b1);
      next_cycle();
      chk_all("post_rst", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized tail against a plain 17-bit subtraction reference
      m_res    = 16'h0002;
      m_bor    = 1'b0;
      m_ovf    = 1'b0;
      m_z      = 1'b0;
      m_neg    = 1'b0;
      accepted = 0;
      pulses   = 0;
      for (int i = 0; i < 400; i++) begin
         drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         if (in_valid) begin
            diff     = {1'b0, a} - {1'b0, b};
            m_res    = diff[15:0];
            m_bor    = (a < b);
            m_ovf    = ($signed(a) - $signed(b) > 17'sd32767) ||
                       ($signed(a) - $signed(b) < -17'sd32768);
            m_z      = (a == b);
            m_neg    = diff[15];
            m_ov     = 1'b1;
            accepted++;
         end else begin
            m_ov = 1'b0;
         end
         next_cycle();
         if (out_valid) pulses++;
         chk_all("rand", m_res, m_ov, m_bor, m_ovf, m_z, m_neg);
      end
      chk("rand", "pulse_count", 16'(pulses), 16'(accepted));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
